// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_barrel_shifter
// Brief    : Fully pipelined WIDTH-bit barrel shifter (SLL/SRL/SRA/ROTR) with
//            log2(WIDTH) registered levels, widest shift first, and
//            valid/ready handshakes with per-stage bubble collapsing.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter #(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH),
  localparam int L       = SHAMT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero
);

  localparam logic [1:0] C_OP_SLL = 2'b00;
  localparam logic [1:0] C_OP_SRL = 2'b01;
  localparam logic [1:0] C_OP_SRA = 2'b10;

  // Per-stage pipeline registers
  logic [L-1:0]       valid_q;
  logic [WIDTH-1:0]   data_q  [L];
  logic [SHAMT_W-1:0] shamt_q [L];
  logic [1:0]         op_q    [L];
  logic               zero_q;

  // Per-stage advance enables and next-state data
  logic [L-1:0]       w_adv;
  logic [WIDTH-1:0]   data_d  [L];

  // One shift level with a fixed distance; SRA keeps the MSB, which is the
  // original sign because earlier SRA levels never change bit WIDTH-1.
  function automatic logic [WIDTH-1:0] shift_level(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic             en,
    input int unsigned      amt
  );
    logic [WIDTH-1:0] r;
    r = d;
    if (en) begin
      case (op)
        C_OP_SLL: r = d << amt;
        C_OP_SRL: r = d >> amt;
        C_OP_SRA: r = $unsigned($signed(d) >>> amt);
        default:  r = (d >> amt) | (d << (WIDTH - amt));
      endcase
    end
    return r;
  endfunction

  // Advance chain: a stage may load when it is empty or its successor moves
  always_comb begin
    w_adv        = '0;
    w_adv[L-1]   = !valid_q[L-1] | out_ready;
    for (int k = L - 2; k >= 0; k--) begin
      w_adv[k] = !valid_q[k] | w_adv[k+1];
    end
  end

  // Next data for each stage: stage k applies shift 2^(L-1-k) of the op it receives
  always_comb begin
    data_d[0] = shift_level(in_data, in_op, in_shamt[L-1], 1 << (L - 1));
    for (int k = 1; k < L; k++) begin
      data_d[k] = shift_level(data_q[k-1], op_q[k-1], shamt_q[k-1][L-1-k],
                              1 << (L - 1 - k));
    end
  end

  // Stage registers: flush clears valids and wins over advance; stalled stages hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      zero_q  <= 1'b1;
      for (int k = 0; k < L; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        op_q[k]    <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      if (w_adv[0]) begin
        valid_q[0] <= in_valid;
        data_q[0]  <= data_d[0];
        shamt_q[0] <= in_shamt;
        op_q[0]    <= in_op;
      end
      for (int k = 1; k < L; k++) begin
        if (w_adv[k]) begin
          valid_q[k] <= valid_q[k-1];
          data_q[k]  <= data_d[k];
          shamt_q[k] <= shamt_q[k-1];
          op_q[k]    <= op_q[k-1];
        end
      end
      if (w_adv[L-1]) begin
        zero_q <= (data_d[L-1] == '0);
      end
    end
  end

  // The last stage's shift amount and opcode are carried but never consumed
  logic w_unused;
  assign w_unused = ^{shamt_q[L-1], op_q[L-1]};

  assign in_ready  = w_adv[0];
  assign out_valid = valid_q[L-1];
  assign out_data  = data_q[L-1];
  assign out_zero  = zero_q;

endmodule
`default_nettype wire

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, fully pipelined barrel shifter for the MIPS datapath shift unit.
- Supports SLL, SRL, SRA and ROTR on a WIDTH-bit operand.
- Built as log2(WIDTH) registered shift levels. Level k shifts by 2^(L-1-k), so the widest shift comes first.
- Valid/ready handshakes on both sides, with per-stage bubble collapsing. Sustains one operation per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of 2, ≥ 4.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, never overridden.
- L, SHAMT_W, number of pipeline levels and the latency in cycles; derived.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous; clears all stage valid bits
- in_valid  input  1  input operation valid
- in_ready  output  1  shifter can accept an operation this cycle
- in_data  input  WIDTH  operand
- in_shamt  input  SHAMT_W  shift amount
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTR
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  shifted result
- out_zero  output  1  out_data == 0; registered alongside out_data

Behaviour:
- Reset (rst_n low, async):
  - All stage valid bits = 0; all stage data, shamt and op registers = 0.
  - out_valid=0, out_data=0, out_zero=1.
  - in_ready=1 from the first cycle after rst_n deasserts.
- Stage k (k=0..L-1):
  - Holds valid_k, data_k, shamt_k, op_k.
  - Applies a shift of 2^(L-1-k) if shamt bit (L-1-k) of the incoming op is set.
  - Stage L-1 drives out_data, out_valid and out_zero.
- Fill rules per level:
  - SLL: zero-fill from the LSB side.
  - SRL: zero-fill from the MSB side.
  - SRA: fill with the original operand's bit WIDTH-1 (carried unchanged through the stages).
  - ROTR: bits shifted out of the LSB end re-enter at the MSB end.
- Advance rule:
  - adv_{L-1} = !valid_{L-1} | out_ready.
  - adv_k = !valid_k | adv_{k+1}.
  - in_ready = adv_0 (combinational from downstream, not from in_valid).
  - A stage with adv_k=1 loads from the previous stage, or from the inputs for stage 0. Its valid becomes the previous valid (in_valid & in_ready for stage 0).
  - A stage with adv_k=0 holds all of its registers.
- Latency and throughput:
  - An op accepted in cycle T (in_valid & in_ready) appears with out_valid=1 in cycle T+L, provided no stall occurs.
  - Throughput is 1 op/cycle while out_ready=1.
- Backpressure:
  - With out_ready=0, the pipe absorbs bubbles and accepts until all L stages are valid, then in_ready=0.
  - out_data and out_zero are stable while out_valid=1 & out_ready=0.
- Ordering: strictly in order; no loss and no duplication under any pattern of valid/ready.
- shamt=0 passes in_data through unchanged for all ops after L cycles.
- Flush:
  - All valid bits go to 0 on the next edge; data registers need not clear.
  - An op presented with in_valid in the flush cycle is discarded.
  - Flush has priority over advance.
- in_op values are all legal; there is no error output.
- Reset mid-operation: all in-flight ops are dropped. out_valid falls asynchronously with rst_n.

Test Plan:
1. Reset → out_valid=0, out_data=0, out_zero=1, in_ready=1; hold rst_n low with in_valid=1 → nothing accepted.
2. WIDTH=32, single ops with out_ready=1. Each result appears exactly 5 cycles after acceptance:
   - SRL 0x80000000 by 16 → 0x00008000.
   - SRA 0x80000000 by 4 → 0xF8000000.
   - SLL 0x00000001 by 31 → 0x80000000.
   - ROTR 0x12345678 by 8 → 0x78123456.
   - SRL 0x0000FFFF by 16 → 0x00000000 with out_zero=1.
3. Back-to-back streaming: 20 random ops on consecutive cycles with out_ready=1 → 20 results on 20 consecutive cycles, matching a reference model in order.
4. Backpressure:
   - Hold out_ready=0 and offer 7 ops → 5 accepted, then in_ready=0; out_data stays stable.
   - Toggle out_ready randomly for 200 cycles → order preserved, no loss or duplication.
5. Flush with 3 ops in flight plus in_valid=1 in the same cycle → next cycle all valids=0, in_ready=1, and no result for any of the 4 ops.
6. Assert rst_n low asynchronously with the pipe full → out_valid=0 immediately; after release, a new op SLL 0x3 by 1 → 0x6 at latency 5.
